// File: rtl/spi_pkg.sv
// spi_pkg: sequencer FSM states and the queue pointer width helper
package spi_pkg;
  typedef enum logic [2:0] {IDLE, START, WAIT_LO, WAIT_HI, STORE, PAUSE} state_t;
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/spi_fifo.sv
// spi_fifo: first-word fall-through queue; a pop frees room for a push in the same cycle
module spi_fifo
  import spi_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop) rp <= rp + PW'(1);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/spi_master_seq.sv
// spi_master_seq: feeds queued words to an external SPI master and queues its replies
module spi_master_seq
  import spi_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             tx_full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_dat,
  output logic             rx_empty,
  output logic             st,
  output logic [WIDTH-1:0] mtx_dat,
  input  logic             load,
  input  logic [WIDTH-1:0] mrx_dat,
  output logic             busy,
  output logic             err,
  input  logic             clr_err
);
  localparam int CW = $clog2(GAP + 1);
  state_t state;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] tx_head;
  logic tx_empty, rx_full, store, ovf;
  assign store = state == STORE;
  assign mtx_dat = tx_empty ? '0 : tx_head;
  assign ovf = (wr_en && tx_full && !store) || (store && rx_full && !rd_en);
  spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx (
    .clk(clk), .rst(rst), .push(wr_en), .pop(store), .din(wr_dat),
    .dout(tx_head), .full(tx_full), .empty(tx_empty)
  );
  spi_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx (
    .clk(clk), .rst(rst), .push(store), .pop(rd_en), .din(mrx_dat),
    .dout(rd_dat), .full(rx_full), .empty(rx_empty)
  );
  // st and busy are registered from the next-state decision
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      st <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= ovf || (err && !clr_err);
      st <= state == IDLE && !tx_empty;
      busy <= !((state == IDLE && tx_empty) || (state == PAUSE && cnt == '0));
      case (state)
        IDLE:    if (!tx_empty) state <= START;
        START:   state <= WAIT_LO;
        WAIT_LO: if (!load) state <= WAIT_HI;
        WAIT_HI: if (load) state <= STORE;
        STORE: begin
          state <= PAUSE;
          cnt <= CW'(GAP - 1);
        end
        PAUSE:   if (cnt == '0) state <= IDLE; else cnt <= cnt - CW'(1);
        default: state <= IDLE;
      endcase
    end
endmodule
